// File: rtl/radix_mult_arbiter_if.sv
// Requester and multiplier signals of one shared radix-4 multiplier.
// The arbiter uses the slave modport; requesters and the multiplier use master.
interface radix_mult_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_x;
  logic [N_REQ*WIDTH-1:0] req_y;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       done;
  logic                   err;
  logic [2*WIDTH-1:0]     result;
  logic                   busy;
  logic [WIDTH-1:0]       mul_x;
  logic [WIDTH-1:0]       mul_y;
  logic                   mul_start;
  logic                   mul_reset;
  logic                   mul_ready;
  logic [2*WIDTH-1:0]     mul_result;

  modport slave (
    input  req, req_x, req_y, mul_ready, mul_result,
    output grant, done, err, result, busy, mul_x, mul_y, mul_start, mul_reset
  );

  modport master (
    output req, req_x, req_y, mul_ready, mul_result,
    input  grant, done, err, result, busy, mul_x, mul_y, mul_start, mul_reset
  );
endinterface

// File: rtl/radix_mult_arbiter.sv
// Shares one multiplier among N_REQ requesters; round-robin, or fixed priority with RADIX_ARB_FIXED_PRIO_EN.
// Latency: multiplier latency + 3 cycles; other requesters hold req until the arbiter returns to IDLE.
module radix_mult_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input logic                  clk,
  input logic                  reset,
  radix_mult_arbiter_if.slave  bus
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ABORT} state_t;

  state_t             state;
  logic [N_REQ-1:0]   grant_q;
  logic [N_REQ-1:0]   done_q;
  logic               err_q;
  logic [2*WIDTH-1:0] result_q;
  logic [WIDTH-1:0]   mul_x_q;
  logic [WIDTH-1:0]   mul_y_q;
  logic               mul_start_q;
  logic               ready_q;
  logic [CW-1:0]      cnt;
  logic [PW-1:0]      win_idx;
  logic [WIDTH-1:0]   win_x;
  logic [WIDTH-1:0]   win_y;
  logic               rise;
`ifndef RADIX_ARB_FIXED_PRIO_EN
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      cand;
  logic               found;
`endif

  always_comb begin
    win_idx = '0;
`ifdef RADIX_ARB_FIXED_PRIO_EN
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) win_idx = PW'(i);
    end
`else
    found = 1'b0;
    cand  = '0;
    // Search begins just after the last owner so every requester gets a turn.
    for (int i = 1; i <= N_REQ; i++) begin
      cand = PW'((int'(ptr) + i) % N_REQ);
      if (!found && bus.req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
`endif
    win_x = '0;
    win_y = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == PW'(i)) begin
        win_x = bus.req_x[i*WIDTH +: WIDTH];
        win_y = bus.req_y[i*WIDTH +: WIDTH];
      end
    end
  end

  // A ready level still high from an earlier operation must not count as completion.
  assign rise = bus.mul_ready & ~ready_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant_q     <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      result_q    <= '0;
      mul_x_q     <= '0;
      mul_y_q     <= '0;
      mul_start_q <= 1'b0;
      ready_q     <= 1'b0;
      cnt         <= '0;
`ifndef RADIX_ARB_FIXED_PRIO_EN
      ptr         <= PW'(N_REQ - 1);
`endif
    end else begin
      ready_q     <= bus.mul_ready;
      mul_start_q <= 1'b0;
      done_q      <= '0;
      err_q       <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            grant_q     <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
            mul_x_q     <= win_x;
            mul_y_q     <= win_y;
            mul_start_q <= 1'b1;
`ifndef RADIX_ARB_FIXED_PRIO_EN
            ptr         <= win_idx;
`endif
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // Completion takes precedence over a timeout landing in the same cycle.
          if (rise) begin
            result_q <= bus.mul_result;
            done_q   <= grant_q;
            state    <= DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            state <= ABORT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ABORT: begin
          result_q <= '0;
          done_q   <= grant_q;
          err_q    <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          grant_q <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.result    = result_q;
  assign bus.busy      = (state != IDLE);
  assign bus.mul_x     = mul_x_q;
  assign bus.mul_y     = mul_y_q;
  assign bus.mul_start = mul_start_q;
  assign bus.mul_reset = reset | (state == ABORT);

endmodule

// File: tb/tb_radix_mult_arbiter.sv
// Directed bench for radix_mult_arbiter with a behavioural multiplier stub.
module tb_radix_mult_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int T = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  radix_mult_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();
  radix_mult_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Stub modes: 0 = multiplier with fixed latency, 1 = ready stuck high, 2 = ready/result driven by the bench.
  int             mode = 0;
  int             lat = 3;
  logic           man_rdy = 1'b0;
  logic [2*W-1:0] man_res = '0;
  logic           s_rdy = 1'b0;
  logic [2*W-1:0] s_res = '0;
  logic [2*W-1:0] s_prod = '0;
  int             s_cnt = 0;

  always @(posedge clk) begin
    if (bus.mul_reset) begin
      s_cnt <= 0;
      s_rdy <= 1'b0;
      s_res <= '0;
    end else if (bus.mul_start) begin
      s_cnt  <= lat;
      s_rdy  <= 1'b0;
      s_prod <= bus.mul_x * bus.mul_y;
    end else if (s_cnt != 0) begin
      s_cnt <= s_cnt - 1;
      if (s_cnt == 1) begin
        s_rdy <= 1'b1;
        s_res <= s_prod;
      end
    end
  end

  assign bus.mul_ready  = (mode == 1) ? 1'b1 : (mode == 2) ? man_rdy : s_rdy;
  assign bus.mul_result = (mode == 2) ? man_res : s_res;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int             idx;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [2*W-1:0] res;
  } vec_t;

  vec_t vecs[6];

  // One complete operation from a single requester; done expected lat+3 cycles after the request edge.
  task automatic run_op(input int idx, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [2*W-1:0] exp_res);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    bus.req_x[idx*W +: W] = x;
    bus.req_y[idx*W +: W] = y;
    bus.req[idx] = 1'b1;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("op_grant", 32'(bus.grant), 32'(1 << idx));
        chk("op_mul_start", 32'(bus.mul_start), 32'd1);
        chk("op_mul_x", 32'(bus.mul_x), 32'(x));
        chk("op_mul_y", 32'(bus.mul_y), 32'(y));
      end
      if (bus.done != '0) begin
        seen = 1'b1;
        chk("op_latency", 32'(n), 32'(lat + 3));
        chk("op_done", 32'(bus.done), 32'(1 << idx));
        chk("op_result", 32'(bus.result), 32'(exp_res));
        chk("op_err", 32'(bus.err), 32'd0);
        bus.req[idx] = 1'b0;
      end
    end
    chk("op_done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    chk("op_grant_clear", 32'(bus.grant), 32'd0);
    chk("op_done_clear", 32'(bus.done), 32'd0);
    chk("op_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, cyc, got, rst_cnt;
    bit seen;
    logic [N-1:0] pend;
    int exp_order[5];
    logic [2*W-1:0] ctn_res[N];

    vecs[0] = '{0, 8'd18,  8'd100, 16'd1800};
    vecs[1] = '{1, 8'd255, 8'd255, 16'd65025};
    vecs[2] = '{2, 8'd0,   8'd77,  16'd0};
    vecs[3] = '{3, 8'd255, 8'd2,   16'd510};
    vecs[4] = '{0, 8'd1,   8'd1,   16'd1};
    vecs[5] = '{2, 8'd128, 8'd2,   16'd256};
`ifdef RADIX_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    ctn_res = '{16'd20, 16'd60, 16'd120, 16'd200};

    reset = 1'b1;
    bus.req = '0;
    bus.req_x = '0;
    bus.req_y = '0;
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_mul_start", 32'(bus.mul_start), 32'd0);
    chk("rst_mul_x", 32'(bus.mul_x), 32'd0);
    chk("rst_mul_reset", 32'(bus.mul_reset), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("rel_mul_reset", 32'(bus.mul_reset), 32'd0);
    chk("rel_busy", 32'(bus.busy), 32'd0);

    // Contention: all four held, each re-raised the cycle after its done.
    for (int i = 0; i < N; i++) begin
      bus.req_x[i*W +: W] = 8'(i + 2);
      bus.req_y[i*W +: W] = 8'(10 * (i + 1));
    end
    bus.req = 4'hF;
    pend = '0;
    n = 0;
    cyc = 0;
    got = 0;
    while (n < 5 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      bus.req = bus.req | pend;
      pend = '0;
      if (bus.done != '0) begin
        for (int i = 0; i < N; i++) if (bus.done[i]) got = i;
        chk("ctn_order", 32'(got), 32'(exp_order[n]));
        chk("ctn_result", 32'(bus.result), 32'(ctn_res[got]));
        bus.req = bus.req & ~bus.done;
        pend = bus.done;
        n++;
      end
    end
    chk("ctn_count", 32'(n), 32'd5);
    bus.req = '0;
    repeat (2) @(negedge clk);
    chk("ctn_idle", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 6; i++) run_op(vecs[i].idx, vecs[i].x, vecs[i].y, vecs[i].res);

    // Ready stuck high: timeout, one-cycle multiplier reset, done with err.
    mode = 1;
    repeat (2) @(negedge clk);
    bus.req_x[2*W +: W] = 8'd5;
    bus.req_y[2*W +: W] = 8'd7;
    bus.req[2] = 1'b1;
    rst_cnt = 0;
    for (int k = 1; k <= T + 4; k++) begin
      @(negedge clk);
      if (bus.mul_reset) rst_cnt++;
      if (k == 1) chk("stk_grant", 32'(bus.grant), 32'd4);
      if (k == T + 1) chk("stk_no_early_done", 32'(bus.done), 32'd0);
      if (k == T + 2) begin
        chk("stk_mul_reset", 32'(bus.mul_reset), 32'd1);
        chk("stk_done_in_abort", 32'(bus.done), 32'd0);
      end
      if (k == T + 3) begin
        chk("stk_done", 32'(bus.done), 32'd4);
        chk("stk_err", 32'(bus.err), 32'd1);
        chk("stk_result", 32'(bus.result), 32'd0);
        bus.req[2] = 1'b0;
      end
      if (k == T + 4) begin
        chk("stk_grant_clear", 32'(bus.grant), 32'd0);
        chk("stk_err_clear", 32'(bus.err), 32'd0);
        chk("stk_idle", 32'(bus.busy), 32'd0);
      end
    end
    chk("stk_reset_pulses", 32'(rst_cnt), 32'd1);

    // Ready rises in the last WAIT cycle before timeout: normal completion.
    mode = 2;
    man_rdy = 1'b0;
    man_res = 16'h1234;
    repeat (2) @(negedge clk);
    bus.req_x[0 +: W] = 8'd9;
    bus.req_y[0 +: W] = 8'd9;
    bus.req[0] = 1'b1;
    rst_cnt = 0;
    for (int k = 1; k <= T + 3; k++) begin
      @(negedge clk);
      if (bus.mul_reset) rst_cnt++;
      if (k == T + 1) begin
        chk("late_no_done", 32'(bus.done), 32'd0);
        man_rdy = 1'b1;
      end
      if (k == T + 2) begin
        chk("late_done", 32'(bus.done), 32'd1);
        chk("late_err", 32'(bus.err), 32'd0);
        chk("late_result", 32'(bus.result), 32'h1234);
        bus.req[0] = 1'b0;
      end
      if (k == T + 3) chk("late_idle", 32'(bus.busy), 32'd0);
    end
    chk("late_no_mul_reset", 32'(rst_cnt), 32'd0);

    // Requester drops req mid-WAIT; operation still completes.
    mode = 0;
    repeat (2) @(negedge clk);
    bus.req_x[3*W +: W] = 8'd255;
    bus.req_y[3*W +: W] = 8'd2;
    bus.req[3] = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 3) bus.req[3] = 1'b0;
      if (bus.done != '0) begin
        seen = 1'b1;
        chk("drop_done", 32'(bus.done), 32'd8);
        chk("drop_result", 32'(bus.result), 32'd510);
        chk("drop_err", 32'(bus.err), 32'd0);
      end
    end
    chk("drop_done_seen", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    chk("drop_idle", 32'(bus.busy), 32'd0);
    chk("drop_grant", 32'(bus.grant), 32'd0);

    // Reset during WAIT of requester 1.
    mode = 2;
    man_rdy = 1'b0;
    @(negedge clk);
    bus.req_x[1*W +: W] = 8'd3;
    bus.req_y[1*W +: W] = 8'd3;
    bus.req[1] = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    chk("mid_grant", 32'(bus.grant), 32'd2);
    reset = 1'b1;
    bus.req = '0;
    @(negedge clk);
    chk("mid_rst_grant", 32'(bus.grant), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_err", 32'(bus.err), 32'd0);
    chk("mid_rst_result", 32'(bus.result), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_mul_x", 32'(bus.mul_x), 32'd0);
    chk("mid_rst_mul_reset", 32'(bus.mul_reset), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rel_mul_reset", 32'(bus.mul_reset), 32'd0);
    chk("mid_rel_done", 32'(bus.done), 32'd0);
    mode = 0;
    bus.req_x[0 +: W] = 8'd6;
    bus.req_y[0 +: W] = 8'd7;
    bus.req = 4'b0111;
    @(negedge clk);
    chk("post_rst_grant", 32'(bus.grant), 32'd1);
    chk("post_rst_mul_x", 32'(bus.mul_x), 32'd6);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.done != '0) begin
        seen = 1'b1;
        chk("post_rst_done", 32'(bus.done), 32'd1);
        chk("post_rst_result", 32'(bus.result), 32'd42);
        bus.req = '0;
      end
    end
    chk("post_rst_done_seen", 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
    chk("post_rst_idle", 32'(bus.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
